// File: rtl/conv_5_result_writer_pkg.sv
// Shared defaults, FSM state encoding and sizing helpers for the layer-5 result writer.
package conv_5_result_writer_pkg;

  localparam int unsigned L5_MAP_W      = 8;
  localparam int unsigned L5_MAP_H      = 8;
  localparam int unsigned L5_ADDR_W     = 7;
  localparam int unsigned L5_ACC_W      = 20;
  localparam int unsigned L5_SHIFT      = 8;
  localparam int unsigned L5_READY_ROWS = 2;
  localparam int unsigned PIX_W         = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } wr_state_t;

  // Counter width able to hold the value n itself (counts run 0..n).
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/requant_clamp.sv
// Combinational round-half-up, arithmetic right shift and clamp to unsigned 8 bits.
module requant_clamp
  import conv_5_result_writer_pkg::*;
#(
  parameter int unsigned ACC_W = L5_ACC_W,
  parameter int unsigned SHIFT = L5_SHIFT
) (
  input  logic [ACC_W-1:0] acc,
  output logic [PIX_W-1:0] q_c
);

  localparam int unsigned R_W    = ACC_W + 1;
  localparam int unsigned RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic [R_W-1:0] RND = (SHIFT > 0) ? (R_W'(1) << RND_SH) : '0;

  logic signed [R_W-1:0] r;
  logic signed [R_W-1:0] q;

  // One guard bit keeps the rounding add from wrapping at the positive limit.
  assign r = $signed({acc[ACC_W-1], acc}) + $signed(RND);
  assign q = r >>> SHIFT;

  always_comb begin
    q_c = q[PIX_W-1:0];
    if (q[R_W-1]) begin
      q_c = '0;
    end else if (q > $signed(R_W'(255))) begin
      q_c = '1;
    end
  end

endmodule

// File: rtl/conv_5_result_writer.sv
// Layer-5 feature-map RAM write side: accepts raster accumulators, requantises,
// writes them out and raises the ready/complete levels that layer 6 waits on.
module conv_5_result_writer
  import conv_5_result_writer_pkg::*;
#(
  parameter int unsigned MAP_W      = L5_MAP_W,
  parameter int unsigned MAP_H      = L5_MAP_H,
  parameter int unsigned ADDR_W     = L5_ADDR_W,
  parameter int unsigned ACC_W      = L5_ACC_W,
  parameter int unsigned SHIFT      = L5_SHIFT,
  parameter int unsigned READY_ROWS = L5_READY_ROWS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              layer_5_write_begin,
  input  logic              acc_valid,
  input  logic [ACC_W-1:0]  acc_in,
  output logic              wr_en,
  output logic [ADDR_W-1:0] layer_5_write_addr,
  output logic [PIX_W-1:0]  d_out,
  output logic              conv_5_ready,
  output logic              conv_5_write_complete,
  output logic              overflow_flag
);

  localparam int unsigned TOTAL     = MAP_W * MAP_H;
  localparam int unsigned READY_CNT = READY_ROWS * MAP_W;
  localparam int unsigned CNT_W     = cnt_width(TOTAL);

  wr_state_t        state;
  logic [CNT_W-1:0] accept_cnt;
  logic [CNT_W-1:0] write_cnt;
  logic [PIX_W-1:0] q_c;
  logic             accept_c;
  logic             start_c;
  logic             last_wr_c;
  logic             ready_hit_c;

  requant_clamp #(
    .ACC_W (ACC_W),
    .SHIFT (SHIFT)
  ) u_requant (
    .acc (acc_in),
    .q_c (q_c)
  );

  assign accept_c    = (state == WRITE) && acc_valid && (accept_cnt < CNT_W'(TOTAL));
  assign start_c     = (state == IDLE) && layer_5_write_begin;
  // Flags track completed writes, so they rise at the edge closing the qualifying write.
  assign last_wr_c   = wr_en && (write_cnt == CNT_W'(TOTAL - 1));
  assign ready_hit_c = wr_en && (write_cnt == CNT_W'(READY_CNT - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state                 <= IDLE;
      accept_cnt            <= '0;
      write_cnt             <= '0;
      wr_en                 <= 1'b0;
      layer_5_write_addr    <= '0;
      d_out                 <= '0;
      conv_5_ready          <= 1'b0;
      conv_5_write_complete <= 1'b0;
      overflow_flag         <= 1'b0;
    end else begin
      wr_en <= accept_c;
      if (accept_c) begin
        layer_5_write_addr <= ADDR_W'(accept_cnt);
        d_out              <= q_c;
        accept_cnt         <= accept_cnt + CNT_W'(1);
      end
      if (wr_en) begin
        write_cnt <= write_cnt + CNT_W'(1);
      end

      // A dropped beat on the starting edge must still leave the flag set.
      if (acc_valid && !accept_c) begin
        overflow_flag <= 1'b1;
      end else if (start_c) begin
        overflow_flag <= 1'b0;
      end

      case (state)
        IDLE: begin
          conv_5_ready          <= 1'b0;
          conv_5_write_complete <= 1'b0;
          if (layer_5_write_begin) begin
            state      <= WRITE;
            accept_cnt <= '0;
            write_cnt  <= '0;
          end
        end
        WRITE: begin
          if (ready_hit_c) begin
            conv_5_ready <= 1'b1;
          end
          if (last_wr_c) begin
            conv_5_write_complete <= 1'b1;
            state                 <= DONE;
          end
        end
        DONE: begin
          if (!layer_5_write_begin) begin
            state                 <= IDLE;
            conv_5_ready          <= 1'b0;
            conv_5_write_complete <= 1'b0;
          end
        end
        default: begin
          state                 <= IDLE;
          conv_5_ready          <= 1'b0;
          conv_5_write_complete <= 1'b0;
        end
      endcase
    end
  end

endmodule
